// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port driven by the UART boot loader.
// master: loader side, slave: imem side.
interface imem_uart_loader_if #(parameter int ADDR_W = 12);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output imem_we, imem_addr, imem_wdata);
  modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// UART (8N1) boot loader: SYNC, LEN16, LEN little-endian words -> imem, then releases cpu_rst.
// Optional trailing XOR checksum byte when CHECKSUM_EN is defined.
module imem_uart_loader #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         ADDR_W       = 12,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                uart_rx,
  imem_uart_loader_if.master  imem,
  output logic                cpu_rst,
  output logic                busy,
  output logic                err
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [16:0] MAX_LEN = 17'(2**ADDR_W);

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  rx_st_t      rx_st, rx_nxt;
  logic [2:0]  rx_sync;  // [1:0] synchronizer, [2] previous synced value for edge detect
  logic        rx_bit, rx_fall, cnt_done;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  rx_sh;
  logic        byte_vld, frame_err;

  assign rx_bit  = rx_sync[1];
  assign rx_fall = rx_sync[2] & ~rx_sync[1];
  assign cnt_done = (rx_st == R_START) ? (cnt == CW'(HALF - 1)) : (cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      R_IDLE:  if (rx_fall) rx_nxt = R_START;
      R_START: if (cnt_done) rx_nxt = rx_bit ? R_IDLE : R_DATA;
      R_DATA:  if (cnt_done && bit_idx == 3'd7) rx_nxt = R_STOP;
      R_STOP:  if (cnt_done) rx_nxt = R_IDLE;
      default: rx_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_st     <= R_IDLE;
      rx_sync   <= '1;
      cnt       <= '0;
      bit_idx   <= '0;
      rx_sh     <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_st     <= rx_nxt;
      rx_sync   <= {rx_sync[1:0], uart_rx};
      cnt       <= (rx_st == R_IDLE || cnt_done) ? '0 : cnt + 1'b1;
      byte_vld  <= (rx_st == R_STOP) && cnt_done && rx_bit;
      frame_err <= (rx_st == R_STOP) && cnt_done && !rx_bit;
      if (rx_st == R_START) bit_idx <= '0;
      if (rx_st == R_DATA && cnt_done) begin
        rx_sh   <= {rx_bit, rx_sh[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // ---------------- Frame loader ----------------
`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} ld_st_t;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {S_SYNC, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR} ld_st_t;
`endif
  ld_st_t      ld_st, ld_nxt;
  logic [15:0] len, wcnt, len_full;
  logic [1:0]  idx;

  assign len_full = {rx_sh, len[7:0]};
  assign busy     = (ld_st != S_SYNC) && (ld_st != S_DONE) && (ld_st != S_ERR);
  assign err      = (ld_st == S_ERR);

  always_comb begin
    ld_nxt = ld_st;
    if (frame_err && ld_st != S_DONE) ld_nxt = S_ERR;
    else if (byte_vld) begin
      case (ld_st)
        S_SYNC: if (rx_sh == SYNC_BYTE) ld_nxt = S_LEN0;
        S_LEN0: ld_nxt = S_LEN1;
        S_LEN1: ld_nxt = (len_full == 16'd0 || {1'b0, len_full} > MAX_LEN) ? S_ERR : S_DATA;
        S_DATA:
          if (idx == 2'd3 && wcnt == len - 16'd1)
`ifdef CHECKSUM_EN
            ld_nxt = S_CSUM;
        S_CSUM: ld_nxt = (rx_sh == csum) ? S_DONE : S_ERR;
`else
            ld_nxt = S_DONE;
`endif
        default: ld_nxt = ld_st;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ld_st <= S_SYNC;
    else        ld_st <= ld_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem.imem_we    <= 1'b0;
      imem.imem_addr  <= '0;
      imem.imem_wdata <= '0;
      cpu_rst         <= 1'b1;
      len             <= '0;
      wcnt            <= '0;
      idx             <= '0;
`ifdef CHECKSUM_EN
      csum            <= '0;
`endif
    end else begin
      imem.imem_we <= 1'b0;
      cpu_rst      <= (ld_st != S_DONE);
      // word counter advances the cycle after the strobe so imem_addr is the pre-increment count
      if (imem.imem_we) wcnt <= wcnt + 1'b1;
      if (byte_vld) begin
        case (ld_st)
          S_LEN0: len[7:0] <= rx_sh;
          S_LEN1: begin
            len[15:8] <= rx_sh;
            wcnt      <= '0;
            idx       <= '0;
`ifdef CHECKSUM_EN
            csum      <= '0;
`endif
          end
          S_DATA: begin
            imem.imem_wdata[{idx, 3'b000} +: 8] <= rx_sh;
            idx <= idx + 1'b1;
`ifdef CHECKSUM_EN
            csum <= csum ^ rx_sh;
`endif
            if (idx == 2'd3) begin
              imem.imem_we   <= 1'b1;
              imem.imem_addr <= wcnt[ADDR_W-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: table of UART frames plus hand-written
// framing-error and mid-frame reset sequences.
module tb_imem_uart_loader;
  localparam int CPB = 8;
  localparam int AW  = 12;

  logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1;
  logic cpu_rst, busy, err;

  imem_uart_loader_if #(.ADDR_W(AW)) imem ();

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .imem(imem),
    .cpu_rst(cpu_rst), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] st_data[$];
  int          st_addr[$];
  logic        st_crst[$];

  always @(negedge clk) if (imem.imem_we) begin
    st_data.push_back(imem.imem_wdata);
    st_addr.push_back(int'(imem.imem_addr));
    st_crst.push_back(cpu_rst);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_ok = 1'b1);
    @(negedge clk) uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    st_data.delete(); st_addr.delete(); st_crst.delete();
  endtask

  function automatic logic [7:0] byte_at(input logic [127:0] v, input int n, input int i);
    return v[8*(n-1-i) +: 8];
  endfunction

  task automatic chk_writes(input string tag, input int nstb, input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] ew;
    chk({tag, " strobes"}, st_data.size(), nstb);
    for (int k = 0; k < nstb; k++) begin
      ew = (k == 0) ? w0 : w1;
      chk($sformatf("%s addr%0d", tag, k), (k < st_addr.size()) ? st_addr[k] : -1, k);
      chk($sformatf("%s data%0d", tag, k), (k < st_data.size()) ? st_data[k] : 32'hxxxx_xxxx, ew);
      chk($sformatf("%s crst_at_stb%0d", tag, k), (k < st_crst.size()) ? st_crst[k] : 1'bx, 1'b1);
    end
  endtask

  typedef struct {
    string        name;
    logic [127:0] v;
    int           n;
    int           nstb;
    logic [31:0]  w0, w1;
    logic         e, crst;
    int           ia; logic ba;  // busy expected after byte ia
    int           ib; logic bb;  // busy expected after byte ib
  } vec_t;

  vec_t vt[$];

  initial begin
    vec_t t;
`ifdef CHECKSUM_EN
    vt.push_back('{"t1", 128'hA5_02_00_05_00_01_20_00_00_00_00_24, 12, 2, 32'h20010005, 0, 0, 0, 0, 1, 11, 0});
    vt.push_back('{"t2", 128'h00_FF_5A_A5_02_00_05_00_01_20_00_00_00_00_24, 15, 2, 32'h20010005, 0, 0, 0, 2, 0, 3, 1});
    vt.push_back('{"t5bad", 128'hA5_02_00_05_00_01_20_00_00_00_00_25, 12, 2, 32'h20010005, 0, 1, 1, 10, 1, 11, 0});
`else
    vt.push_back('{"t1", 128'hA5_02_00_05_00_01_20_00_00_00_00, 11, 2, 32'h20010005, 0, 0, 0, 0, 1, 10, 0});
    vt.push_back('{"t2", 128'h00_FF_5A_A5_02_00_05_00_01_20_00_00_00_00, 14, 2, 32'h20010005, 0, 0, 0, 2, 0, 3, 1});
`endif
    vt.push_back('{"t3len0", 128'hA5_00_00, 3, 0, 0, 0, 1, 1, 1, 1, 2, 0});
    vt.push_back('{"t3lenbig", 128'hA5_01_10, 3, 0, 0, 0, 1, 1, 1, 1, 2, 0});

    // reset state
    repeat (3) @(negedge clk);
    chk("rst we", imem.imem_we, 0);
    chk("rst addr", imem.imem_addr, 0);
    chk("rst wdata", imem.imem_wdata, 0);
    chk("rst cpu_rst", cpu_rst, 1);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    rst_n = 1'b1;

    foreach (vt[j]) begin
      t = vt[j];
      do_reset();
      for (int i = 0; i < t.n; i++) begin
        send(byte_at(t.v, t.n, i));
        if (i == t.ia) chk({t.name, " busy_a"}, busy, t.ba);
        if (i == t.ib) chk({t.name, " busy_b"}, busy, t.bb);
      end
      repeat (20) @(negedge clk);
      chk_writes(t.name, t.nstb, t.w0, t.w1);
      chk({t.name, " err"}, err, t.e);
      chk({t.name, " cpu_rst"}, cpu_rst, t.crst);
    end

    // bad stop bit on the 3rd payload byte, remaining bytes must be ignored
    do_reset();
    send(8'hA5); send(8'h02); send(8'h00); send(8'h05); send(8'h00);
    send(8'h01, 1'b0);
    repeat (4) @(negedge clk);
    chk("t4 err_now", err, 1);
    send(8'h20); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    repeat (20) @(negedge clk);
    chk("t4 strobes", st_data.size(), 0);
    chk("t4 err", err, 1);
    chk("t4 cpu_rst", cpu_rst, 1);
    chk("t4 busy", busy, 0);

    // reset in the middle of the 2nd word, then a clean frame
    do_reset();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h05); send(8'h00); send(8'h01); send(8'h20);
    send(8'h00); send(8'h00);
    chk("t6 pre strobes", st_data.size(), 1);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk("t6 rst we", imem.imem_we, 0);
    chk("t6 rst addr", imem.imem_addr, 0);
    chk("t6 rst wdata", imem.imem_wdata, 0);
    chk("t6 rst cpu_rst", cpu_rst, 1);
    chk("t6 rst busy", busy, 0);
    chk("t6 rst err", err, 0);
    rst_n = 1'b1;
    st_data.delete(); st_addr.delete(); st_crst.delete();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h05); send(8'h00); send(8'h01); send(8'h20);
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
`ifdef CHECKSUM_EN
    send(8'h24);
`endif
    repeat (20) @(negedge clk);
    chk_writes("t6", 2, 32'h20010005, 32'h0);
    chk("t6 err", err, 0);
    chk("t6 cpu_rst", cpu_rst, 0);
    // done state ignores further traffic, including a bad stop bit
    send(8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    chk("t6 done_hold err", err, 0);
    chk("t6 done_hold cpu_rst", cpu_rst, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
